// File: rtl/tl_bram_ctrl.sv
// TileLink-UL slave controller for a 512x32 byte-maskable block RAM with a 1-cycle registered read.
// Requests issue straight to the RAM ports; responses return in order through a 3-entry shift FIFO.
module tl_bram_ctrl #(
  parameter int unsigned TL_AW = 32,
  parameter int unsigned TL_SW = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tl_a_valid_i,
  output logic             tl_a_ready_o,
  input  logic [2:0]       tl_a_opcode_i,
  input  logic [2:0]       tl_a_param_i,
  input  logic [1:0]       tl_a_size_i,
  input  logic [TL_SW-1:0] tl_a_source_i,
  input  logic [TL_AW-1:0] tl_a_address_i,
  input  logic [3:0]       tl_a_mask_i,
  input  logic [31:0]      tl_a_data_i,
  input  logic             tl_a_corrupt_i,
  output logic             tl_d_valid_o,
  input  logic             tl_d_ready_i,
  output logic [2:0]       tl_d_opcode_o,
  output logic [1:0]       tl_d_param_o,
  output logic [1:0]       tl_d_size_o,
  output logic [TL_SW-1:0] tl_d_source_o,
  output logic             tl_d_denied_o,
  output logic             tl_d_corrupt_o,
  output logic [31:0]      tl_d_data_o,
  output logic [8:0]       bram_rd_addr_o,
  input  logic [31:0]      bram_rd_data_i,
  output logic             bram_wr_en_o,
  output logic [8:0]       bram_wr_addr_o,
  output logic [31:0]      bram_wr_data_o,
  output logic [3:0]       bram_wr_bm_o
);

  localparam int unsigned DW    = 32;
  localparam int unsigned MW    = 4;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned OCC_W = 3;

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] D_ACK       = 3'd0;
  localparam logic [2:0] D_ACK_DATA  = 3'd1;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [1:0]       size;
    logic [TL_SW-1:0] source;
    logic             denied;
    logic             corrupt;
    logic [DW-1:0]    data;
  } rsp_t;

  logic             w_acc;
  logic             w_is_put_full;
  logic             w_is_put_part;
  logic             w_is_put;
  logic             w_is_get;
  logic [MW-1:0]    w_lane_mask;
  logic             w_misalign;
  logic             w_err;
  logic [OCC_W-1:0] w_occ;
  logic             w_push;
  logic             w_pop;
  logic             w_placed;
  rsp_t             w_push_rsp;
  rsp_t [DEPTH-1:0] w_q_nxt;
  logic [DEPTH-1:0] w_vld_nxt;
  logic             w_unused;

  logic             r_inflight;
  logic             r_st_get;
  logic [1:0]       r_st_size;
  logic [TL_SW-1:0] r_st_source;
  logic             r_st_err;
  rsp_t [DEPTH-1:0] r_q;
  logic [DEPTH-1:0] r_vld;

  // Upper address bits are decoded by the crossbar; param carries nothing for UL.
  assign w_unused = ^{tl_a_param_i, tl_a_address_i[TL_AW-1:11]};

  assign w_is_put_full = (tl_a_opcode_i == OP_PUT_FULL);
  assign w_is_put_part = (tl_a_opcode_i == OP_PUT_PART);
  assign w_is_put      = w_is_put_full | w_is_put_part;
  assign w_is_get      = (tl_a_opcode_i == OP_GET);

  // Byte lanes covered by size/address; size 3 cannot fit a 32-bit beat.
  always_comb begin
    w_lane_mask = '0;
    w_misalign  = 1'b0;
    case (tl_a_size_i)
      2'd0: w_lane_mask = 4'b0001 << tl_a_address_i[1:0];
      2'd1: begin
        w_lane_mask = tl_a_address_i[1] ? 4'b1100 : 4'b0011;
        w_misalign  = tl_a_address_i[0];
      end
      2'd2: begin
        w_lane_mask = 4'b1111;
        w_misalign  = |tl_a_address_i[1:0];
      end
      default: begin
        w_lane_mask = '0;
        w_misalign  = 1'b1;
      end
    endcase
  end

  assign w_err = ~(w_is_put | w_is_get)
               | w_misalign
               | (w_is_put & tl_a_corrupt_i)
               | (w_is_put_full & (tl_a_mask_i != w_lane_mask))
               | (w_is_put_part & (|(tl_a_mask_i & ~w_lane_mask)));

  // Occupancy counts the in-flight stage so the FIFO can never overflow.
  always_comb begin
    w_occ = OCC_W'(r_inflight);
    for (int i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + OCC_W'(r_vld[i]);
    end
  end

  assign tl_a_ready_o = rst_ni & (w_occ < OCC_W'(DEPTH));
  assign w_acc        = tl_a_valid_i & tl_a_ready_o;

  assign bram_rd_addr_o = tl_a_address_i[10:2];
  assign bram_wr_addr_o = tl_a_address_i[10:2];
  assign bram_wr_data_o = tl_a_data_i;
  assign bram_wr_bm_o   = tl_a_mask_i;
  assign bram_wr_en_o   = w_acc & w_is_put & ~w_err;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_inflight  <= 1'b0;
      r_st_get    <= 1'b0;
      r_st_size   <= '0;
      r_st_source <= '0;
      r_st_err    <= 1'b0;
    end else begin
      r_inflight <= w_acc;
      if (w_acc) begin
        r_st_get    <= w_is_get;
        r_st_size   <= tl_a_size_i;
        r_st_source <= tl_a_source_i;
        r_st_err    <= w_err;
      end
    end
  end

  // Stage output meets the RAM read data one cycle after issue.
  always_comb begin
    w_push_rsp         = '0;
    w_push_rsp.opcode  = r_st_get ? D_ACK_DATA : D_ACK;
    w_push_rsp.size    = r_st_size;
    w_push_rsp.source  = r_st_source;
    w_push_rsp.denied  = r_st_err;
    w_push_rsp.corrupt = r_st_get & r_st_err;
    w_push_rsp.data    = (r_st_get & ~r_st_err) ? bram_rd_data_i : '0;
  end

  assign w_push = r_inflight;
  assign w_pop  = r_vld[0] & tl_d_ready_i;

  // Shift FIFO: entry 0 is always the head, so D comes straight from flops.
  always_comb begin
    w_q_nxt   = r_q;
    w_vld_nxt = r_vld;
    w_placed  = 1'b0;
    if (w_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        w_q_nxt[i]   = r_q[i+1];
        w_vld_nxt[i] = r_vld[i+1];
      end
      w_q_nxt[DEPTH-1]   = '0;
      w_vld_nxt[DEPTH-1] = 1'b0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (w_push && !w_placed && !w_vld_nxt[i]) begin
        w_q_nxt[i]   = w_push_rsp;
        w_vld_nxt[i] = 1'b1;
        w_placed     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_q   <= '0;
      r_vld <= '0;
    end else begin
      r_q   <= w_q_nxt;
      r_vld <= w_vld_nxt;
    end
  end

  assign tl_d_valid_o   = r_vld[0];
  assign tl_d_opcode_o  = r_q[0].opcode;
  assign tl_d_param_o   = 2'b00;
  assign tl_d_size_o    = r_q[0].size;
  assign tl_d_source_o  = r_q[0].source;
  assign tl_d_denied_o  = r_q[0].denied;
  assign tl_d_corrupt_o = r_q[0].corrupt;
  assign tl_d_data_o    = r_q[0].data;

endmodule

// File: tb/tb_tl_bram_ctrl.sv
// Directed bench for tl_bram_ctrl with a behavioural RAM, a reference memory and an in-order response scoreboard.
module tb_tl_bram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [1:0]  a_size;
  logic [3:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        a_corrupt;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [1:0]  d_size;
  logic [3:0]  d_source;
  logic        d_denied;
  logic        d_corrupt;
  logic [31:0] d_data;
  logic [8:0]  rd_addr;
  logic [31:0] rd_data;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_bm;

  always #5 clk = ~clk;

  tl_bram_ctrl #(.TL_AW(32), .TL_SW(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .tl_a_valid_i   (a_valid),
    .tl_a_ready_o   (a_ready),
    .tl_a_opcode_i  (a_opcode),
    .tl_a_param_i   (a_param),
    .tl_a_size_i    (a_size),
    .tl_a_source_i  (a_source),
    .tl_a_address_i (a_address),
    .tl_a_mask_i    (a_mask),
    .tl_a_data_i    (a_data),
    .tl_a_corrupt_i (a_corrupt),
    .tl_d_valid_o   (d_valid),
    .tl_d_ready_i   (d_ready),
    .tl_d_opcode_o  (d_opcode),
    .tl_d_param_o   (d_param),
    .tl_d_size_o    (d_size),
    .tl_d_source_o  (d_source),
    .tl_d_denied_o  (d_denied),
    .tl_d_corrupt_o (d_corrupt),
    .tl_d_data_o    (d_data),
    .bram_rd_addr_o (rd_addr),
    .bram_rd_data_i (rd_data),
    .bram_wr_en_o   (wr_en),
    .bram_wr_addr_o (wr_addr),
    .bram_wr_data_o (wr_data),
    .bram_wr_bm_o   (wr_bm)
  );

  // Behavioural block RAM: byte-masked write, registered read, never reset.
  logic [31:0] ram [0:511] = '{default: 32'h0};
  always @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (wr_bm[b]) ram[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
    end
    rd_data <= ram[rd_addr];
  end

  typedef struct {
    int          acc_cyc;
    logic [44:0] rsp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_mem [0:511];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          n_acc    = 0;
  int          cyc      = 0;
  bit          rst_prev = 1'b0;

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [2:0] op, input logic [1:0] sz,
                                     input logic [31:0] addr, input logic [3:0] mask,
                                     input logic cor);
    int unsigned nbytes;
    logic [3:0]  lanes;
    bit          is_put;
    if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) return 1'b1;
    if (sz == 2'd3) return 1'b1;
    nbytes = 1 << sz;
    if ((addr % nbytes) != 0) return 1'b1;
    lanes  = 4'(((1 << nbytes) - 1) << addr[1:0]);
    is_put = (op == 3'd0) || (op == 3'd1);
    if (is_put && cor) return 1'b1;
    if (op == 3'd0 && mask != lanes) return 1'b1;
    if (op == 3'd1 && (mask & ~lanes) != 4'h0) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: sample everything on the falling edge, then advance.
  task automatic tick();
    logic        err;
    logic        is_get;
    logic        is_put;
    logic [31:0] word;
    exp_t        e;
    @(negedge clk);
    if (!rst_n) begin
      chk(64'(a_ready), 64'(0), "rst_a_ready");
      chk(64'(wr_en), 64'(0), "rst_wr_en");
      if (rst_prev) begin
        chk(64'(d_valid), 64'(0), "rst_d_valid");
        chk(64'({d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data}), 64'(0), "rst_d_fields");
      end
      sb.delete();
      rst_prev = 1'b1;
    end else begin
      rst_prev = 1'b0;
      chk(64'(a_ready), 64'(sb.size() < 3), "a_ready");
      chk(64'(d_valid), 64'(sb.size() > 0 && cyc >= sb[0].acc_cyc + 2), "d_valid");
      chk(64'(rd_addr), 64'(a_address[10:2]), "rd_addr");
      if (a_valid && a_ready) begin
        err    = model_err(a_opcode, a_size, a_address, a_mask, a_corrupt);
        is_get = (a_opcode == 3'd4);
        is_put = (a_opcode == 3'd0) || (a_opcode == 3'd1);
        chk(64'(wr_en), 64'(is_put && !err), "wr_en");
        if (is_put && !err)
          chk(64'({wr_addr, wr_bm, wr_data}), 64'({a_address[10:2], a_mask, a_data}), "wr_fields");
        word = (is_get && !err) ? ref_mem[a_address[10:2]] : 32'h0;
        e.acc_cyc = cyc;
        e.rsp = {(is_get ? 3'd1 : 3'd0), 2'd0, a_size, a_source, err, (is_get && err), word};
        sb.push_back(e);
        if (is_put && !err)
          for (int b = 0; b < 4; b++)
            if (a_mask[b]) ref_mem[a_address[10:2]][8*b +: 8] = a_data[8*b +: 8];
        n_acc++;
      end else begin
        chk(64'(wr_en), 64'(0), "wr_en_idle");
      end
      if (d_valid && d_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk(64'({d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data}), 64'(e.rsp), "d_resp");
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] sz, input logic [3:0] src,
                      input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                      input logic cor, output int waits);
    int n0;
    a_opcode  = op;
    a_size    = sz;
    a_source  = src;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
    a_corrupt = cor;
    a_valid   = 1'b1;
    waits     = 0;
    n0        = n_acc;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (n_acc != n0) break;
      waits++;
    end
    chk(64'(n_acc != n0), 64'(1), "accept");
    a_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sb.size() > 0; k++) tick();
    chk(64'(sb.size()), 64'(0), "drain");
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n0;
    for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;
    rst_n = 1'b0; a_valid = 1'b0; d_ready = 1'b1;
    a_opcode = 3'd4; a_param = 3'd0; a_size = 2'd2; a_source = 4'd0;
    a_address = 32'h0; a_mask = 4'hF; a_data = 32'h0; a_corrupt = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Full write then read back
    send(3'd0, 2'd2, 4'd1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, w);
    send(3'd4, 2'd2, 4'd2, 32'h10, 4'hF, 32'h0, 1'b0, w);
    drain();

    // Partial writes of several sizes
    send(3'd1, 2'd2, 4'd3, 32'h10, 4'h2, 32'h0000AA00, 1'b0, w);
    send(3'd4, 2'd2, 4'd4, 32'h10, 4'h0, 32'h0, 1'b0, w);
    send(3'd1, 2'd0, 4'd5, 32'h13, 4'h8, 32'h77000000, 1'b0, w);
    send(3'd0, 2'd1, 4'd6, 32'h16, 4'hC, 32'h55660000, 1'b0, w);
    send(3'd4, 2'd2, 4'd7, 32'h10, 4'hF, 32'h0, 1'b0, w);
    send(3'd4, 2'd1, 4'd8, 32'h16, 4'hF, 32'h0, 1'b0, w);
    drain();

    // Streaming: one accept per cycle
    for (int s = 0; s < 8; s++) begin
      send(3'd4, 2'd2, 4'(s), 32'(32'h10 + 4 * s), 4'hF, 32'h0, 1'b0, w);
      chk(64'(w), 64'(0), "stream_wait");
    end
    drain();

    // Backpressure: three accepted, fourth stalls until a pop
    d_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      send(3'd4, 2'd2, 4'(9 + s), 32'(32'h20 + 4 * s), 4'hF, 32'h0, 1'b0, w);
      chk(64'(w), 64'(0), "bp_wait");
    end
    a_opcode = 3'd4; a_size = 2'd2; a_source = 4'd12; a_address = 32'h10; a_valid = 1'b1;
    n0 = n_acc;
    repeat (4) tick();
    chk(64'(n_acc - n0), 64'(0), "bp_stalled");
    chk(64'(sb.size()), 64'(3), "bp_queued");
    d_ready = 1'b1;
    send(3'd4, 2'd2, 4'd12, 32'h10, 4'hF, 32'h0, 1'b0, w);
    send(3'd4, 2'd2, 4'd13, 32'h14, 4'hF, 32'h0, 1'b0, w);
    drain();

    // Error cases never write the RAM
    send(3'd2, 2'd2, 4'd1, 32'h20, 4'hF, 32'h11111111, 1'b0, w);
    send(3'd4, 2'd3, 4'd2, 32'h20, 4'hF, 32'h0, 1'b0, w);
    send(3'd4, 2'd2, 4'd3, 32'h2, 4'hF, 32'h0, 1'b0, w);
    send(3'd0, 2'd2, 4'd4, 32'h0, 4'h7, 32'h12345678, 1'b0, w);
    send(3'd0, 2'd2, 4'd5, 32'h10, 4'hF, 32'hBAD0BAD0, 1'b1, w);
    send(3'd1, 2'd1, 4'd6, 32'h10, 4'h4, 32'h00330000, 1'b0, w);
    send(3'd4, 2'd2, 4'd7, 32'h0, 4'hF, 32'h0, 1'b0, w);
    send(3'd4, 2'd2, 4'd8, 32'h20, 4'hF, 32'h0, 1'b0, w);
    send(3'd4, 2'd2, 4'd9, 32'h10, 4'hF, 32'h0, 1'b0, w);
    drain();

    // Reset with responses queued
    send(3'd0, 2'd2, 4'd10, 32'h40, 4'hF, 32'hCAFEF00D, 1'b0, w);
    drain();
    d_ready = 1'b0;
    send(3'd4, 2'd2, 4'd11, 32'h40, 4'hF, 32'h0, 1'b0, w);
    send(3'd4, 2'd2, 4'd12, 32'h10, 4'hF, 32'h0, 1'b0, w);
    repeat (2) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    d_ready = 1'b1;
    repeat (4) tick();
    send(3'd4, 2'd2, 4'd14, 32'h40, 4'hF, 32'h0, 1'b0, w);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
